// File: rtl/hex_display_scheduler.sv
// Purpose: round-robin sharing of one 8-digit hex display between two requesters, with minimum dwell.
// Latency: accept at edge t with display idle (IDLE/HOLD) -> new value on disp_* after edge t+1.
// Backpressure: reqX_ready = !pendX (registered); a full one-deep buffer stalls its requester until it is loaded.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/data/blank   requester 0 handshake, 32-bit hex value, 8-bit blank mask (1 = digit off)
//   req1_valid/ready/data/blank   requester 1, same meaning
//   disp_in, disp_blank     registered value / blank mask driven to the multiplexed hex display
//   owner                   requester whose value is currently on the display (reset 1)
//   busy                    high while a value is inside its guaranteed dwell window (SHOW)
//
// Optional build macro: DISP_BLINK_EN -- while HOLDing a stale value, blink it by toggling
// disp_blank between the stored mask and 8'hFF every BLINK_CYCLES cycles.

module hex_display_scheduler #(
  parameter int DWELL_CYCLES = 1000,
  parameter int CNT_W        = 16,
  parameter int BLINK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [7:0]  req0_blank,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [7:0]  req1_blank,
  output logic [31:0] disp_in,
  output logic [7:0]  disp_blank,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_RELOAD = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // One-deep holding buffer per requester.
  logic [31:0] buf0_data, buf1_data;
  logic [7:0]  buf0_blank, buf1_blank;
  logic        pend0, pend1;

  logic acc0, acc1;
  logic slot_free;
  logic load;
  logic gnt;

  // Ready comes straight from a flop, so there is no valid->ready combinational path.
  assign req0_ready = !pend0;
  assign req1_ready = !pend1;

  assign acc0 = req0_valid && !pend0;
  assign acc1 = req1_valid && !pend1;

  // The display can take a new value when idle, holding, or at the last dwell cycle.
  assign slot_free = (state == IDLE) || (state == HOLD) ||
                     ((state == SHOW) && (cnt == '0));
  assign load      = slot_free && (pend0 || pend1);

  // Tie goes to the requester that does not currently own the display; with only
  // one pending, that one wins even if it owned the previous slot.
  assign gnt = (pend0 && pend1) ? ~owner : pend1;

  // ------------------------------------------------------------------
  // Request buffers. Accept and load of the same buffer can never coincide:
  // accept needs pendX = 0, load of X needs pendX = 1.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0      <= 1'b0;
      buf0_data  <= '0;
      buf0_blank <= '0;
    end else if (acc0) begin
      pend0      <= 1'b1;
      buf0_data  <= req0_data;
      buf0_blank <= req0_blank;
    end else if (load && !gnt) begin
      pend0      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1      <= 1'b0;
      buf1_data  <= '0;
      buf1_blank <= '0;
    end else if (acc1) begin
      pend1      <= 1'b1;
      buf1_data  <= req1_data;
      buf1_blank <= req1_blank;
    end else if (load && gnt) begin
      pend1      <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Display FSM with registered outputs. cnt is the dwell down-counter in
  // SHOW and, in blink builds, the blink half-period counter in HOLD.
  // ------------------------------------------------------------------
`ifdef DISP_BLINK_EN
  logic [7:0] shown_blank;  // mask of the value on screen, restored between blink-off phases
  logic       blink_off;    // 1 while disp_blank is forced to all-off

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      disp_in     <= '0;
      disp_blank  <= 8'hFF;
      shown_blank <= 8'hFF;
      blink_off   <= 1'b0;
      owner       <= 1'b1;
      busy        <= 1'b0;
    end else if (load) begin
      // Load wins over any blink toggle, so the new mask appears on this edge.
      disp_in     <= gnt ? buf1_data  : buf0_data;
      disp_blank  <= gnt ? buf1_blank : buf0_blank;
      shown_blank <= gnt ? buf1_blank : buf0_blank;
      blink_off   <= 1'b0;
      owner       <= gnt;
      cnt         <= DWELL_RELOAD;
      state       <= SHOW;
      busy        <= 1'b1;
    end else begin
      case (state)
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            // Dwell done with nothing waiting: start HOLD in the "on" phase.
            state     <= HOLD;
            busy      <= 1'b0;
            cnt       <= BLINK_RELOAD;
            blink_off <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt        <= BLINK_RELOAD;
            blink_off  <= ~blink_off;
            disp_blank <= blink_off ? shown_blank : 8'hFF;
          end
        end
        default: begin
          // IDLE: display stays blank until the first load.
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      disp_in    <= '0;
      disp_blank <= 8'hFF;
      owner      <= 1'b1;
      busy       <= 1'b0;
    end else if (load) begin
      disp_in    <= gnt ? buf1_data  : buf0_data;
      disp_blank <= gnt ? buf1_blank : buf0_blank;
      owner      <= gnt;
      cnt        <= DWELL_RELOAD;
      state      <= SHOW;
      busy       <= 1'b1;
    end else begin
      case (state)
        SHOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            // Dwell done with nothing waiting: keep the value up, steady.
            state <= HOLD;
            busy  <= 1'b0;
            cnt   <= BLINK_RELOAD;
          end
        end
        default: begin
          // IDLE / HOLD: outputs unchanged until the next load.
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Purpose: self-checking bench for hex_display_scheduler (DWELL_CYCLES = 4, BLINK_CYCLES = 2).
// Latency: table vectors are driven #1 after an edge and compared #1 after the next edge.
// Backpressure: a scoreboard captures every accepted request and checks it at its load.

module tb_hex_display_scheduler;

  localparam int DWELL = 4;
`ifdef DISP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [7:0]  req0_blank = '0, req1_blank = '0;
  logic [31:0] disp_in;
  logic [7:0]  disp_blank;
  logic        owner, busy;

  hex_display_scheduler #(
    .DWELL_CYCLES(DWELL),
    .CNT_W(16),
    .BLINK_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_blank(req0_blank),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_blank(req1_blank),
    .disp_in(disp_in), .disp_blank(disp_blank), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  b;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   accepts = 0;
  int   loads = 0;
  int   cyc = 0;
  bit   log_en = 1'b0;
  logic log_owner[$];
  int   log_cyc[$];

  // Accept side of the scoreboard: whatever the DUT takes is what it must show later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (req0_valid && req0_ready) begin
          q0.push_back({req0_data, req0_blank});
          accepts++;
        end
        if (req1_valid && req1_ready) begin
          q1.push_back({req1_data, req1_blank});
          accepts++;
        end
      end
    end
  end

  // Load side: a load is a busy rising edge, or a fresh dwell window starting
  // right after a full DWELL-cycle window.
  initial begin
    int   run;
    bit   prev_busy;
    ent_t e;
    run = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        run = 0;
        prev_busy = 1'b0;
      end else begin
        bit is_load;
        is_load = 1'b0;
        if (busy) begin
          if (!prev_busy || run == DWELL) begin
            is_load = 1'b1;
            run = 1;
          end else begin
            run++;
          end
        end else begin
          run = 0;
        end
        prev_busy = busy;
        if (is_load) begin
          loads++;
          if (log_en) begin
            log_owner.push_back(owner);
            log_cyc.push_back(cyc);
          end
          checks++;
          if ((owner == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            errors++;
            $display("FAIL sb_empty: load for owner %0d with nothing accepted (disp_in=%h)", owner, disp_in);
          end else begin
            e = (owner == 1'b0) ? q0.pop_front() : q1.pop_front();
            if (disp_in !== e.d || disp_blank !== e.b) begin
              errors++;
              $display("FAIL sb_data: owner %0d got %h/%h, expected %h/%h", owner, disp_in, disp_blank, e.d, e.b);
            end
          end
        end
      end
    end
  end

  // Table records: inputs for one edge, expected outputs right after it.
  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic [7:0]  b0;
    logic        v1;
    logic [31:0] d1;
    logic [7:0]  b1;
    logic [43:0] exp_out;  // {disp_in, disp_blank, owner, busy, req0_ready, req1_ready}
  } vec_t;

  function automatic vec_t mk(logic v0, logic [31:0] d0, logic [7:0] b0,
                              logic v1, logic [31:0] d1, logic [7:0] b1,
                              logic [31:0] ein, logic [7:0] eb, logic eo, logic ebusy,
                              logic er0, logic er1);
    vec_t r;
    r.v0 = v0; r.d0 = d0; r.b0 = b0;
    r.v1 = v1; r.d1 = d1; r.b1 = b1;
    r.exp_out = {ein, eb, eo, ebusy, er0, er1};
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tv[17];

  initial begin
    // Both requesters at once from reset (req0 wins the tie), then req1,
    // then a single req0 request out of HOLD.
    tv[0]  = mk(1, 32'hAAAA_AAAA, 8'h00, 1, 32'hBBBB_BBBB, 8'h18, 32'h0,         8'hFF, 1, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0,                                 32'hAAAA_AAAA, 8'h00, 0, 1, 1, 0);
    tv[2]  = tv[1];
    tv[3]  = tv[1];
    tv[4]  = tv[1];
    tv[5]  = mk(0, 0, 0, 0, 0, 0,                                 32'hBBBB_BBBB, 8'h18, 1, 1, 1, 1);
    tv[6]  = tv[5];
    tv[7]  = tv[5];
    tv[8]  = tv[5];
    tv[9]  = mk(0, 0, 0, 0, 0, 0,                                 32'hBBBB_BBBB, 8'h18, 1, 0, 1, 1);
    tv[10] = mk(1, 32'h1234_5678, 8'h00, 0, 0, 0,                 32'hBBBB_BBBB, 8'h18, 1, 0, 0, 1);
    tv[11] = mk(0, 0, 0, 0, 0, 0,                                 32'h1234_5678, 8'h00, 0, 1, 1, 1);
    tv[12] = tv[11];
    tv[13] = tv[11];
    tv[14] = tv[11];
    tv[15] = mk(0, 0, 0, 0, 0, 0,                                 32'h1234_5678, 8'h00, 0, 0, 1, 1);
    tv[16] = tv[15];

    // ---- reset values ----
    #12;
    check("reset_out", {20'h0, disp_in, disp_blank, owner, busy, req0_ready, req1_ready},
          {20'h0, 32'h0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- table-driven cycle vectors ----
    for (int i = 0; i < 17; i++) begin
      req0_valid = tv[i].v0; req0_data = tv[i].d0; req0_blank = tv[i].b0;
      req1_valid = tv[i].v1; req1_data = tv[i].d1; req1_blank = tv[i].b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {20'h0, disp_in, disp_blank, owner, busy, req0_ready, req1_ready},
            {20'h0, tv[i].exp_out});
    end
    check("table_drained", {32'h0, q0.size() + q1.size()}, 64'h0);

    // ---- both requesters continuously valid for 20 edges ----
    do_reset();
    log_owner.delete();
    log_cyc.delete();
    begin
      int acc_base, load_base;
      bit drained;
      acc_base = accepts;
      load_base = loads;
      log_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
        req0_valid = 1'b1; req0_data = $urandom; req0_blank = 8'($urandom_range(0, 255));
        req1_valid = 1'b1; req1_data = $urandom; req1_blank = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drained = 1'b0;
      for (int i = 0; i < 60 && !drained; i++) begin
        @(posedge clk);
        #1;
        if (!busy && req0_ready && req1_ready) drained = 1'b1;
      end
      @(negedge clk);
      log_en = 1'b0;
      check("cont_drain", {63'h0, drained}, 64'h1);
      check("cont_acc_eq_load", 64'(accepts - acc_base), 64'(loads - load_base));
      check("cont_queues_empty", {32'h0, q0.size() + q1.size()}, 64'h0);
      check("cont_enough_loads", {63'h0, log_owner.size() >= 5}, 64'h1);
      for (int i = 1; i < log_owner.size(); i++) begin
        check($sformatf("cont_alt%0d", i), {63'h0, log_owner[i]}, {63'h0, ~log_owner[i-1]});
        check($sformatf("cont_gap%0d", i), 64'(log_cyc[i] - log_cyc[i-1]), 64'(DWELL));
      end
    end

    // ---- asynchronous reset in the middle of SHOW with req1 pending ----
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h0BAD_CAFE; req0_blank = 8'h00;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    #1 req1_valid = 1'b1; req1_data = 32'hDEAD_BEEF; req1_blank = 8'h00;
    @(posedge clk);
    #1 req1_valid = 1'b0;
    check("mid_show_state", {62'h0, busy, req1_ready}, {62'h0, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", {20'h0, disp_in, disp_blank, owner, busy, req0_ready, req1_ready},
          {20'h0, 32'h0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d", i), {23'h0, disp_in, disp_blank, busy},
            {23'h0, 32'h0, 8'hFF, 1'b0});
    end

    // ---- HOLD display: blink or steady mask ----
    do_reset();
    req0_valid = 1'b1; req0_data = 32'hCAFE_F00D; req0_blank = 8'h0F;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    begin
      bit seen_busy, in_hold;
      seen_busy = 1'b0;
      in_hold = 1'b0;
      for (int i = 0; i < 40 && !in_hold; i++) begin
        @(posedge clk);
        #1;
        if (busy) seen_busy = 1'b1;
        else if (seen_busy) in_hold = 1'b1;
      end
      check("hold_reached", {63'h0, in_hold}, 64'h1);
      if (in_hold) begin
        for (int k = 0; k < 6; k++) begin
          logic [7:0] exp_b;
          exp_b = (BLINK && (k == 2 || k == 3)) ? 8'hFF : 8'h0F;
          check($sformatf("hold_blank%0d", k), {24'h0, disp_in, disp_blank},
                {24'h0, 32'hCAFE_F00D, exp_b});
          @(posedge clk);
          #1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
